operand_collector: RTL and testbench

Parametrised operand-collection stage between decode and execute. Generalises single-cycle operand fetch to NPORTS source ports and NFWD forwarding sources. Holds one decoded instruction until every used operand has been captured, either from the register file or from a forwarding source. Operands whose producer has not yet written back are waited on, not stalled-and-refetched. Decouples decode from execute with a valid/ready handshake and adds a flush and a stall-cycle counter.

---
 rtl/operand_collector.sv | 207 ++++++++++++++++++++
 tb/tb_operand_collector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// operand_collector
//   Holds one decoded instruction between decode and execute until every
//   used source operand has been captured. Each operand comes either from the
//   register file or from one of NFWD forwarding buses. Operands whose
//   producer has not written back yet are waited on in place, not refetched.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            drop the held instruction (mispredict)
//   in_valid/ready   decode handshake; in_meta, in_use, in_raddr describe it
//   rd_addr          addresses shown to the register file / hazard unit
//   rf_data          register-file read data for rd_addr
//   fwd_sel          per port: 0 = rf_data, k = fwd_data source k-1
//   fwd_pending      per port: producer of rd_addr has not finished yet
//   fwd_data         forwarding buses
//   out_valid/ready  execute handshake; out_meta, out_data are registered
//   stall_cnt        saturating count of cycles spent waiting in COLLECT
module operand_collector #(
  parameter int NPORTS = 6,
  parameter int NFWD   = 6,
  parameter int XLEN   = 32,
  parameter int RADDR  = 6,
  parameter int META_W = 128,
  parameter int FSEL   = $clog2(NFWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [META_W-1:0]         in_meta,
  input  logic [NPORTS-1:0]         in_use,
  input  logic [NPORTS*RADDR-1:0]   in_raddr,
  output logic [NPORTS*RADDR-1:0]   rd_addr,
  input  logic [NPORTS*XLEN-1:0]    rf_data,
  input  logic [NPORTS*FSEL-1:0]    fwd_sel,
  input  logic [NPORTS-1:0]         fwd_pending,
  input  logic [NFWD*XLEN-1:0]      fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [META_W-1:0]         out_meta,
  output logic [NPORTS*XLEN-1:0]    out_data,
  output logic [31:0]               stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [META_W-1:0]        meta_r;
  logic [NPORTS*RADDR-1:0]  addr_r;
  // The use mask is folded into cap_r: unused ports are captured at accept.
  logic [NPORTS-1:0]        cap_r;
  logic [NPORTS*XLEN-1:0]   data_r;
  logic                     valid_r;
  logic [31:0]              stall_cnt_r;

  logic                     in_ready_s;
  logic [NPORTS*RADDR-1:0]  rd_addr_s;
  logic                     accept_s;
  logic [NPORTS-1:0]        cap_acc_s;
  logic [NPORTS-1:0]        cap_col_s;
  logic [NPORTS*XLEN-1:0]   sel_data_s;

  // Operand mux: a select of 0 or any value above NFWD falls back to rf_data.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [FSEL-1:0]      sel,
    input logic [XLEN-1:0]      rf,
    input logic [NFWD*XLEN-1:0] fwd
  );
    logic [XLEN-1:0] v;
    v = rf;
    for (int k = 0; k < NFWD; k++) begin
      if (sel == FSEL'(k + 1)) begin
        v = fwd[k*XLEN +: XLEN];
      end
    end
    return v;
  endfunction

  // Selected value per port for the address currently on rd_addr.
  always_comb begin
    sel_data_s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      sel_data_s[p*XLEN +: XLEN] = pick_operand(fwd_sel[p*FSEL +: FSEL],
                                                rf_data[p*XLEN +: XLEN],
                                                fwd_data);
    end
  end

  // Capture masks: what would be captured on accept, and after a COLLECT edge.
  always_comb begin
    cap_acc_s = '0;
    cap_col_s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      cap_acc_s[p] = ~in_use[p] | ~fwd_pending[p];
      cap_col_s[p] = cap_r[p]   | ~fwd_pending[p];
    end
  end

  // FSM outputs: in_ready and the address steering toward the register file.
  always_comb begin
    in_ready_s = 1'b0;
    rd_addr_s  = in_raddr;
    case (state_r)
      ST_EMPTY:   in_ready_s = 1'b1;
      ST_COLLECT: rd_addr_s  = addr_r;
      ST_READY:   in_ready_s = out_ready;
      default:    in_ready_s = 1'b0;
    endcase
  end

  // in_ready may read 1 during flush, but the offered instruction is dropped.
  assign accept_s = in_valid & in_ready_s & ~flush;

  // FSM next state; flush wins over accept and capture.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_next_s = (&cap_acc_s) ? ST_READY : ST_COLLECT;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_COLLECT: begin
          state_next_s = (&cap_col_s) ? ST_READY : ST_COLLECT;
        end
        ST_READY: begin
          if (accept_s) begin
            state_next_s = (&cap_acc_s) ? ST_READY : ST_COLLECT;
          end else if (out_ready) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_READY;
          end
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // FSM state register; out_valid is simply "next state is READY" registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == ST_READY);
    end
  end

  // Held instruction: meta, addresses, capture bits and operand values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      addr_r <= '0;
      cap_r  <= '0;
      data_r <= '0;
    end else if (flush) begin
      cap_r <= '0;
    end else if (accept_s) begin
      meta_r <= in_meta;
      addr_r <= in_raddr;
      cap_r  <= cap_acc_s;
      for (int p = 0; p < NPORTS; p++) begin
        data_r[p*XLEN +: XLEN] <= (in_use[p] & ~fwd_pending[p]) ?
                                  sel_data_s[p*XLEN +: XLEN] : '0;
      end
    end else if (state_r == ST_COLLECT) begin
      cap_r <= cap_col_s;
      // Only still-missing ports load; captured ports keep their value.
      for (int p = 0; p < NPORTS; p++) begin
        if (~cap_r[p] & ~fwd_pending[p]) begin
          data_r[p*XLEN +: XLEN] <= sel_data_s[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Stall counter: counts COLLECT cycles that end with an operand still missing.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_COLLECT) && !flush && !(&cap_col_s) &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign in_ready  = in_ready_s;
  assign rd_addr   = rd_addr_s;
  assign out_valid = valid_r;
  assign out_meta  = meta_r;
  assign out_data  = data_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed steps followed by a
// randomized run, all checked every cycle against a held-instruction model.
module tb_operand_collector;

  localparam int NPORTS = 6;
  localparam int NFWD   = 6;
  localparam int XLEN   = 32;
  localparam int RADDR  = 6;
  localparam int META_W = 128;
  localparam int FSEL   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [META_W-1:0]        in_meta, out_meta;
  logic [NPORTS-1:0]        in_use, fwd_pending;
  logic [NPORTS*RADDR-1:0]  in_raddr, rd_addr;
  logic [NPORTS*XLEN-1:0]   rf_data, out_data;
  logic [NPORTS*FSEL-1:0]   fwd_sel;
  logic [NFWD*XLEN-1:0]     fwd_data;
  logic [31:0]              stall_cnt;

  logic [XLEN-1:0]  rf_a  [NPORTS];
  logic [FSEL-1:0]  sel_a [NPORTS];
  logic [RADDR-1:0] ra_a  [NPORTS];
  logic [XLEN-1:0]  fd_a  [NFWD];

  always_comb begin
    rf_data  = '0;
    fwd_sel  = '0;
    in_raddr = '0;
    fwd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rf_data[p*XLEN +: XLEN]    = rf_a[p];
      fwd_sel[p*FSEL +: FSEL]    = sel_a[p];
      in_raddr[p*RADDR +: RADDR] = ra_a[p];
    end
    for (int k = 0; k < NFWD; k++) fwd_data[k*XLEN +: XLEN] = fd_a[k];
  end

  operand_collector dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta),
    .in_use(in_use), .in_raddr(in_raddr), .rd_addr(rd_addr),
    .rf_data(rf_data), .fwd_sel(fwd_sel), .fwd_pending(fwd_pending),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_meta(out_meta), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  // Reference model: is an instruction held, is it complete, and what it holds.
  bit               m_have, m_done;
  bit               m_cap  [NPORTS];
  logic [META_W-1:0] m_meta;
  logic [RADDR-1:0] m_addr [NPORTS];
  logic [XLEN-1:0]  m_data [NPORTS];
  logic [31:0]      m_stall;
  int               total = 0, bad = 0, xfers = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input int p);
    int s;
    s = int'(sel_a[p]);
    if (s >= 1 && s <= NFWD) return fd_a[s-1];
    return rf_a[p];
  endfunction

  function automatic bit all_cap();
    bit a;
    a = 1'b1;
    for (int p = 0; p < NPORTS; p++) a = a & m_cap[p];
    return a;
  endfunction

  task automatic model_clear();
    m_have = 0; m_done = 0; m_meta = '0; m_stall = 32'd0;
    for (int p = 0; p < NPORTS; p++) begin
      m_cap[p] = 0; m_data[p] = '0; m_addr[p] = '0;
    end
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 1; in_use = '0; fwd_pending = '0;
    in_meta = '0;
    for (int p = 0; p < NPORTS; p++) begin rf_a[p] = '0; sel_a[p] = '0; ra_a[p] = '0; end
    for (int k = 0; k < NFWD; k++) fd_a[k] = '0;
  endtask

  task automatic rand_inputs(input int pend_pct);
    in_meta = {$urandom, $urandom, $urandom, $urandom};
    in_use  = NPORTS'($urandom);
    for (int p = 0; p < NPORTS; p++) begin
      rf_a[p]  = $urandom;
      sel_a[p] = FSEL'($urandom_range(0, 7));
      ra_a[p]  = RADDR'($urandom);
      fwd_pending[p] = ($urandom_range(0, 99) < pend_pct);
    end
    for (int k = 0; k < NFWD; k++) fd_a[k] = $urandom;
  endtask

  // One clock: check combinational outputs, step the model, check registers.
  task automatic cycle();
    bit ready_e;
    logic [RADDR-1:0] ra_e;
    @(negedge clk);
    ready_e = !m_have || (m_done && out_ready);
    if (!rst) begin
      chk("in_ready", 128'(in_ready), 128'(ready_e));
      for (int p = 0; p < NPORTS; p++) begin
        ra_e = (m_have && !m_done) ? m_addr[p] : ra_a[p];
        chk("rd_addr", 128'(rd_addr[p*RADDR +: RADDR]), 128'(ra_e));
      end
    end
    @(posedge clk);
    #1;
    if (!rst && m_have && m_done && out_ready) xfers++;
    if (rst) begin
      model_clear();
    end else if (flush) begin
      m_have = 0;
    end else if (m_have && !m_done) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (!m_cap[p] && !fwd_pending[p]) begin m_cap[p] = 1; m_data[p] = pick(p); end
      end
      m_done = all_cap();
      if (!m_done && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end else if (ready_e && in_valid) begin
      m_have = 1; m_meta = in_meta;
      for (int p = 0; p < NPORTS; p++) begin
        m_addr[p] = ra_a[p];
        m_cap[p]  = !in_use[p] || !fwd_pending[p];
        m_data[p] = (in_use[p] && !fwd_pending[p]) ? pick(p) : '0;
      end
      m_done = all_cap();
    end else if (m_have && out_ready) begin
      m_have = 0;
    end
    chk("out_valid", 128'(out_valid), 128'(m_have && m_done));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    if (m_have && m_done) begin
      chk("out_meta", out_meta, m_meta);
      for (int p = 0; p < NPORTS; p++)
        chk("out_data", 128'(out_data[p*XLEN +: XLEN]), 128'(m_data[p]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cyc;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_meta", out_meta, 128'h0);
    chk("rst_out_data", 128'(out_data), 128'h0);
    chk("rst_stall", 128'(stall_cnt), 128'h0);
    rst = 0;

    // Basic two-operand instruction from the register file.
    in_valid = 1; in_use = 6'b000011; in_meta = 128'hA1;
    for (int p = 0; p < NPORTS; p++) begin rf_a[p] = 32'hF0 + p; ra_a[p] = RADDR'(p + 1); end
    rf_a[0] = 32'h11; rf_a[1] = 32'h22;
    cycle();
    chk("t1_valid", 128'(out_valid), 128'(1'b1));
    chk("t1_p0", 128'(out_data[31:0]), 128'h11);
    chk("t1_p1", 128'(out_data[63:32]), 128'h22);
    chk("t1_p2_5", 128'(out_data[191:64]), 128'h0);
    chk("t1_stall", 128'(stall_cnt), 128'h0);

    // Forwarded operand, then back-to-back with an out-of-range select.
    sel_a[1] = 3'd3; fd_a[2] = 32'hDEAD_BEEF; in_meta = 128'hA2;
    cycle();
    chk("t2_fwd", 128'(out_data[63:32]), 128'hDEAD_BEEF);
    sel_a[1] = 3'd7; rf_a[1] = 32'h77; in_meta = 128'hA3;
    cycle();
    chk("t2_sel7", 128'(out_data[63:32]), 128'h77);
    in_valid = 0;
    cycle();

    // Pending operand released through forwarding source 1 after 3 cycles.
    in_valid = 1; in_meta = 128'hA4; fwd_pending = 6'b000001;
    sel_a[0] = 3'd0; sel_a[1] = 3'd0; rf_a[1] = 32'h33;
    cycle();
    for (int n = 0; n < 3; n++) begin
      for (int p = 0; p < NPORTS; p++) ra_a[p] = RADDR'($urandom);
      rf_a[1] = $urandom; in_meta = 128'hBAD;
      cycle();
      chk("t3_in_ready", 128'(in_ready), 128'(1'b0));
      chk("t3_wait_valid", 128'(out_valid), 128'(1'b0));
    end
    fwd_pending = '0; sel_a[0] = 3'd2; fd_a[1] = 32'h55;
    cycle();
    chk("t3_valid", 128'(out_valid), 128'(1'b1));
    chk("t3_p0", 128'(out_data[31:0]), 128'h55);
    chk("t3_p1_kept", 128'(out_data[63:32]), 128'h33);
    chk("t3_meta", out_meta, 128'hA4);
    chk("t3_stall", 128'(stall_cnt), 128'd3);
    in_valid = 0;
    cycle();

    // Stream of 8 with a 2-cycle out_ready drop in the middle.
    xfers = 0; i = 0; cyc = 0;
    while (i < 8 && cyc < 40) begin
      rand_inputs(0);
      in_meta = 128'(1000 + i);
      in_valid = 1;
      out_ready = !(cyc == 4 || cyc == 5);
      if (!m_have || (m_done && out_ready)) i++;
      cycle();
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    cycle();
    chk("t4_xfers", 128'(xfers), 128'd8);
    chk("t4_cycles", 128'(cyc), 128'd10);

    // Flush while collecting, with a new instruction offered in the same cycle.
    idle_inputs();
    in_valid = 1; in_use = 6'b000001; fwd_pending = 6'b000001; in_meta = 128'hC1;
    cycle();
    flush = 1; fwd_pending = '0; in_meta = 128'hC2;
    cycle();
    chk("t5_flush_valid", 128'(out_valid), 128'(1'b0));
    flush = 0; in_valid = 0;
    cycle();
    chk("t5_discard", 128'(out_valid), 128'(1'b0));

    // Reset while holding a complete instruction.
    in_valid = 1; out_ready = 0; in_use = 6'b111111; in_meta = 128'hD1;
    for (int p = 0; p < NPORTS; p++) rf_a[p] = $urandom | 32'h1;
    cycle();
    in_valid = 0;
    cycle();
    chk("t5_held", 128'(out_valid), 128'(1'b1));
    rst = 1;
    cycle();
    rst = 0; out_ready = 1;
    chk("t5_rst_valid", 128'(out_valid), 128'(1'b0));
    chk("t5_rst_meta", out_meta, 128'h0);
    chk("t5_rst_data", 128'(out_data), 128'h0);
    chk("t5_rst_stall", 128'(stall_cnt), 128'h0);
    cycle();

    // Stall counter saturation.
    in_valid = 1; in_use = 6'b000100; fwd_pending = 6'b000100; in_meta = 128'hE1;
    cycle();
    in_valid = 0;
    force dut.stall_cnt_r = 32'hFFFF_FFFC;
    #1;
    release dut.stall_cnt_r;
    m_stall = 32'hFFFF_FFFC;
    repeat (6) cycle();
    chk("t6_sat", 128'(stall_cnt), 128'hFFFF_FFFF);
    fwd_pending = '0;
    cycle();
    chk("t6_sat_hold", 128'(stall_cnt), 128'hFFFF_FFFF);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rand_inputs(25);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      flush     = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
